// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and stage codes for the AES-128 round sequencer.
//   NB_ROUNDS  - number of AES rounds (AES-128 only)
//   KEY_STEPS  - key pre-expansion steps per round
//   ARK_STEPS  - AddRoundKey steps per round
//   SB_BYTES   - SubBytes byte cycles per round
//   stage_e    - 4-bit stage code seen by key expansion and data path
//   ctrl_state_e - internal sequencer state (stage codes plus KEY_PRE)
package aes_pkg;

    localparam int unsigned NB_ROUNDS = 10;
    localparam int unsigned KEY_STEPS = 6;
    localparam int unsigned ARK_STEPS = 7;
    localparam int unsigned SB_BYTES  = 16;

    localparam int unsigned STAGE_W = 4;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned BYTE_W  = 4;

    typedef enum logic [STAGE_W-1:0] {
        STG_IDLE            = 4'd0,
        STG_ADD_ROUND_KEY   = 4'd1,
        STG_SUB_BYTES       = 4'd2,
        STG_SHIFT_ROWS      = 4'd3,
        STG_MIX_COLUMNS     = 4'd4,
        STG_I_ADD_ROUND_KEY = 4'd5,
        STG_I_SUB_BYTES     = 4'd6,
        STG_I_SHIFT_ROWS    = 4'd7,
        STG_I_MIX_COLUMNS   = 4'd8,
        STG_LOAD            = 4'd9,
        STG_ADD_KEY0        = 4'd10,
        STG_DONE            = 4'd11
    } stage_e;

    // Codes 0..11 coincide with stage_e; KEY_PRE is internal only.
    typedef enum logic [STAGE_W-1:0] {
        ST_IDLE     = 4'd0,
        ST_ARK      = 4'd1,
        ST_SB       = 4'd2,
        ST_SR       = 4'd3,
        ST_MC       = 4'd4,
        ST_IARK     = 4'd5,
        ST_ISB      = 4'd6,
        ST_ISR      = 4'd7,
        ST_IMC      = 4'd8,
        ST_LOAD     = 4'd9,
        ST_ADD_KEY0 = 4'd10,
        ST_DONE     = 4'd11,
        ST_KEY_PRE  = 4'd12
    } ctrl_state_e;

    // Key pre-expansion looks like a forward AddRoundKey to the key unit.
    function automatic stage_e stage_of(input ctrl_state_e s);
        return (s == ST_KEY_PRE) ? STG_ADD_ROUND_KEY : stage_e'(s);
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: request handshake and sequencing outputs of aes_round_ctrl.
//   master - requester side: drives start/decrypt/abort, observes the rest
//   slave  - sequencer side: samples start/decrypt/abort, drives the rest
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic                      start;
    logic                      decrypt;
    logic                      abort;
    logic                      busy;
    logic                      done;
    logic                      key_load;
    logic                      data_load;
    logic                      data_we;
    logic [STAGE_W-1:0]        current_state;
    logic [ROUND_W-1:0]        round;
    logic signed [CNT_W-1:0]   cnt;
    logic [BYTE_W-1:0]         byte_idx;
    logic                      inv_en;
    logic                      last_round;

    modport master (
        output start, decrypt, abort,
        input  busy, done, key_load, data_load, data_we, current_state,
               round, cnt, byte_idx, inv_en, last_round
    );

    modport slave (
        input  start, decrypt, abort,
        output busy, done, key_load, data_load, data_we, current_state,
               round, cnt, byte_idx, inv_en, last_round
    );

endinterface

// File: rtl/aes_step_counter.sv
// aes_step_counter: loadable up-counter that wraps to 0 after last_val.
//   clk, rst  - clock, async active-high reset
//   load      - synchronous load of load_val (priority over en)
//   en        - advance by one, wrapping at last_val
//   last_val  - terminal value
//   count_q   - registered count
//   tc_c      - count_q equals last_val (combinational)
module aes_step_counter #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] last_val,
    output logic [WIDTH-1:0] count_q,
    output logic             tc_c
);

    logic [WIDTH-1:0] count_d;

    assign tc_c = (count_q == last_val);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = tc_c ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for the iterative AES-128 core, one block per
// start/done handshake, encrypt or decrypt (decrypt pre-expands the key first).
//   clk, rst - clock, async active-high reset
//   ctrl     - aes_round_ctrl_if.slave: start/decrypt/abort in; busy, done,
//              key_load, data_load, data_we, current_state, round, cnt,
//              byte_idx, inv_en, last_round out (all registered)
// Build option: AES_CTRL_ABORT_EN enables abort of an in-flight block.
module aes_round_ctrl #(
    parameter int unsigned NB_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    aes_round_ctrl_if.slave  ctrl
);
    import aes_pkg::*;

    localparam logic [ROUND_W-1:0] LAST_ENC = ROUND_W'(NB_ROUNDS);

    ctrl_state_e        state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               dir_q, dir_d;
    stage_e             stage_q, stage_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               key_load_q, key_load_d, data_load_q, data_load_d;
    logic               data_we_q, data_we_d, inv_en_q, inv_en_d;
    logic               last_round_q, last_round_d;
    logic               abort_fire;

    logic [CNT_W-1:0]   cnt_q, cnt_last;
    logic               cnt_tc_c, cnt_en, cnt_clr;
    logic [BYTE_W-1:0]  byte_q;
    logic               byte_tc_c, byte_en, byte_clr;

`ifdef AES_CTRL_ABORT_EN
    assign abort_fire = ctrl.abort && (state_q != ST_IDLE);
`else
    logic abort_unused;
    assign abort_unused = ctrl.abort;
    assign abort_fire   = 1'b0;
`endif

    // Step counters: cnt for key steps / AddRoundKey, byte_idx for SubBytes.
    aes_step_counter #(.WIDTH(CNT_W)) u_cnt (
        .clk(clk), .rst(rst), .load(cnt_clr), .load_val('0), .en(cnt_en),
        .last_val(cnt_last), .count_q(cnt_q), .tc_c(cnt_tc_c)
    );

    aes_step_counter #(.WIDTH(BYTE_W)) u_byte (
        .clk(clk), .rst(rst), .load(byte_clr), .load_val('0), .en(byte_en),
        .last_val(BYTE_W'(SB_BYTES - 1)), .count_q(byte_q), .tc_c(byte_tc_c)
    );

    // Next state and round index.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        dir_d   = dir_q;
        unique case (state_q)
            ST_IDLE: if (ctrl.start) begin
                state_d = ST_LOAD;
                dir_d   = ctrl.decrypt;
                round_d = '0;
            end
            ST_LOAD: if (dir_q) begin
                state_d = ST_KEY_PRE;
                round_d = ROUND_W'(1);
            end else begin
                state_d = ST_ADD_KEY0;
            end
            ST_KEY_PRE: if (cnt_tc_c) begin
                if (round_q == LAST_ENC) state_d = ST_ADD_KEY0;
                else                     round_d = round_q + ROUND_W'(1);
            end
            ST_ADD_KEY0: if (dir_q) begin
                state_d = ST_ISR;
                round_d = round_q - ROUND_W'(1);
            end else begin
                state_d = ST_SB;
                round_d = round_q + ROUND_W'(1);
            end
            ST_SB:  if (byte_tc_c) state_d = ST_SR;
            ST_SR:  state_d = (round_q == LAST_ENC) ? ST_ARK : ST_MC;
            ST_MC:  state_d = ST_ARK;
            ST_ARK: if (cnt_tc_c) begin
                if (round_q == LAST_ENC) begin
                    state_d = ST_DONE;
                    round_d = '0;
                end else begin
                    state_d = ST_SB;
                    round_d = round_q + ROUND_W'(1);
                end
            end
            ST_ISR: state_d = ST_ISB;
            ST_ISB: if (byte_tc_c) state_d = ST_IARK;
            ST_IARK: if (cnt_tc_c) begin
                if (round_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IMC;
                    round_d = round_q - ROUND_W'(1);
                end
            end
            ST_IMC:  state_d = ST_ISR;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_fire) begin
            state_d = ST_IDLE;
            round_d = '0;
        end
    end

    // Counter control: counters sit at 0 whenever the next state does not use them.
    always_comb begin
        cnt_en   = state_q inside {ST_KEY_PRE, ST_ARK, ST_IARK};
        cnt_last = (state_q == ST_KEY_PRE) ? CNT_W'(KEY_STEPS - 1) : CNT_W'(ARK_STEPS - 1);
        cnt_clr  = !(state_d inside {ST_KEY_PRE, ST_ARK, ST_IARK});
        byte_en  = state_q inside {ST_SB, ST_ISB};
        byte_clr = !(state_d inside {ST_SB, ST_ISB});
    end

    // Registered outputs decoded from the next state.
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        key_load_d  = (state_d == ST_LOAD);
        data_load_d = (state_d == ST_LOAD);
        stage_d     = stage_of(state_d);
        // AddRoundKey writes data one step after the key update (cnt 5 -> 6).
        data_we_d   = (state_d inside {ST_ADD_KEY0, ST_SB, ST_SR, ST_MC, ST_ISB, ST_ISR, ST_IMC})
                   || ((state_q inside {ST_ARK, ST_IARK}) && (state_d == state_q)
                       && (cnt_q == CNT_W'(ARK_STEPS - 2)));
        inv_en_d    = (state_d != ST_IDLE) && (state_d != ST_KEY_PRE) && dir_d;
        // Decrypt MixColumns already carries round r-1, so it is excluded.
        last_round_d = ((state_d inside {ST_SB, ST_SR, ST_ARK}) && (round_d == LAST_ENC))
                    || ((state_d inside {ST_ISR, ST_ISB, ST_IARK}) && (round_d == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            round_q      <= '0;
            dir_q        <= 1'b0;
            stage_q      <= STG_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            key_load_q   <= 1'b0;
            data_load_q  <= 1'b0;
            data_we_q    <= 1'b0;
            inv_en_q     <= 1'b0;
            last_round_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            dir_q        <= dir_d;
            stage_q      <= stage_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            key_load_q   <= key_load_d;
            data_load_q  <= data_load_d;
            data_we_q    <= data_we_d;
            inv_en_q     <= inv_en_d;
            last_round_q <= last_round_d;
        end
    end

    assign ctrl.busy          = busy_q;
    assign ctrl.done          = done_q;
    assign ctrl.key_load      = key_load_q;
    assign ctrl.data_load     = data_load_q;
    assign ctrl.data_we       = data_we_q;
    assign ctrl.current_state = stage_q;
    assign ctrl.round         = round_q;
    assign ctrl.cnt           = $signed(cnt_q);
    assign ctrl.byte_idx      = byte_q;
    assign ctrl.inv_en        = inv_en_q;
    assign ctrl.last_round    = last_round_q;

endmodule
